ctrl_decode_stage: RTL and testbench
====================================

# ctrl_decode_stage

Registered, parametrised successor to the combinational main control decoder. It decodes the RV32I opcode, funct3 and funct7 fields into the control bundle and holds that bundle in the ID/EX pipeline register, with a valid/ready handshake on both sides. It inserts a configurable number of load-use bubbles, squashes on flush, flags illegal opcodes, and optionally tags M-extension ops. It sits between the fetch/IF-ID register and the execute stage.

## Interface
- LOAD_BUBBLES, 1, bubbles inserted between a load and a dependent consumer (0..3; 0 disables the interlock)
- ENABLE_M, 0, 1 = decode funct7=0000001 R-type as muldiv (sets is_muldiv)
- clk  input  1  clock; all state updates on its rising edge
- rst_n  input  1  reset, asynchronous and active-low
- in_valid  input  1  instr is valid
- in_ready  output  1  stage accepts instr this cycle
- instr  input  32  instruction word: opcode[6:0], rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20], funct7[31:25]
- flush  input  1  squash the held and the incoming instruction
- out_ready  input  1  execute stage accepts the bundle
- out_valid  output  1  bundle valid
- result_src  output  2;  mem_write, alu_src  output  1 each;  imm_src  output  3;  reg_write  output  1;  alu_op  output  2;  mreq, is_branch, jump, is_utype, is_lui, is_jalr, is_muldiv, illegal  output  1 each: registered control bundle
- rd, rs1, rs2  output  5 each  registered register indices

## Operation
- Field order {result_src, mem_write, alu_src, imm_src, reg_write, alu_op, mreq, is_branch, jump, is_utype, is_lui, is_jalr}. Every "x" in the table below is driven as 0.
- 0000011 load: 01_0_1_000_1_00_1_0_0_0_0_0
- 0010011 op-imm: 00_0_1_000_1_11_0_0_0_0_0_0. imm_src becomes 101 when funct3 is 001 or 101 (shifts).
- 1100111 jalr: 00_0_1_000_1_10_0_1_1_0_0_1
- 0100011 store: 00_1_1_001_0_00_1_0_0_0_0_0
- 0110011 R-type: 00_0_0_000_1_10_0_0_0_0_0_0. is_muldiv = ENABLE_M && funct7==0000001.
- 1100011 branch: 00_0_0_010_0_01_0_1_0_0_0_0
- 1101111 jal: 10_0_0_011_1_00_0_0_1_0_0_0
- 0010111 auipc: 11_0_1_100_1_00_0_0_0_1_0_0
- 0110111 lui: 11_0_1_100_1_00_0_0_0_1_1_0
- Any other opcode: all fields 0 and illegal=1. The bundle still passes downstream with out_valid=1.
- Register usage for hazard checks:
  - rs1 is read by load, op-imm, jalr, store, R-type and branch.
  - rs2 is read by store, R-type and branch.
  - Index 0 never creates a hazard.
- adv = !out_valid | out_ready.
- hazard = (cnt != 0) && in_valid && (rs1 read and rs1 == pend_rd, or rs2 read and rs2 == pend_rd).
- in_ready = adv && !hazard && !flush.
- Accept = in_valid && in_ready. On accept the register loads the decoded bundle and out_valid becomes 1.
- When adv is 1 and nothing is accepted, the register loads a bubble: out_valid=0 and all bundle fields 0.
- Whenever out_valid=0, every bundle field is 0.
- Interlock state is pend_rd[4:0] and cnt[1:0].
  - Accepting a load with rd != 0 sets pend_rd=rd and cnt=LOAD_BUBBLES. A new load reloads both.
  - Otherwise each cycle with adv=1 and cnt != 0 decrements cnt, whether the register loads an instruction or a bubble.
- Flush has priority over everything:
  - next cycle out_valid=0 and the bundle is 0;
  - cnt=0;
  - the incoming instruction is dropped (in_ready=0).
- When out_ready=0 and out_valid=1, the bundle holds stable and cnt holds.

## Timing
- Reset (rst_n low, asynchronous) drives these values immediately:
  - out_valid, the whole bundle, illegal, is_muldiv, rd, rs1, rs2: 0;
  - pend_rd and cnt: 0;
  - in_ready: 1 once rst_n deasserts.
- Latency: an instruction accepted at edge N appears on the outputs after edge N, i.e. one cycle.
- in_ready is combinational from in_valid, instr, flush, out_ready and state. It has no path from itself.
- Back-to-back: a non-dependent stream sustains one instruction per cycle while out_ready=1.
- A load followed by a dependent consumer: the consumer is accepted exactly LOAD_BUBBLES adv-cycles after the load.
- Flush arriving in the same cycle as a hazard or a stall: flush wins.
- Reset asserted mid-stall: the pending hazard is lost; resuming after reset is the caller's responsibility.

## Test plan
- Reset with rst_n=0 mid-stream: all outputs 0 asynchronously. After release: in_ready=1, out_valid=0.
- Stream 0x00500093 (addi), 0x002081B3 (add), 0x0000006F (jal) with out_ready=1:
  - three consecutive valid bundles, one cycle latency;
  - addi: alu_op=11, imm_src=000;
  - jal: result_src=10, jump=1.
- LOAD_BUBBLES=2: lw x5 (0x0002A283) then add x6,x5,x1:
  - add held with in_ready=0 for 2 cycles;
  - out_valid pattern 1,0,0,1;
  - an unrelated add after the lw instead gives no bubble.
- Flush on the cycle a dependent instruction stalls: next cycle out_valid=0 and cnt=0; the next instruction is accepted with no bubble.
- Opcode 0x7F: out_valid=1, illegal=1, all other fields 0. With ENABLE_M=1, mul (0x02208033) gives is_muldiv=1; with ENABLE_M=0 it gives is_muldiv=0.
- out_ready=0 for 3 cycles with a valid bundle: outputs stable, in_ready=0, cnt unchanged; they resume on release.

Source files
------------

// File: rtl/ctrl_decode_stage.sv
// RV32I control decode plus ID/EX pipeline register with load-use interlock and flush.
// Latency 1 cycle; in_ready drops on out_ready stall, load-use hazard or flush.
module ctrl_decode_stage #(
  parameter int LOAD_BUBBLES = 1,
  parameter bit ENABLE_M     = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic        flush,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [1:0]  result_src,
  output logic        mem_write,
  output logic        alu_src,
  output logic [2:0]  imm_src,
  output logic        reg_write,
  output logic [1:0]  alu_op,
  output logic        mreq,
  output logic        is_branch,
  output logic        jump,
  output logic        is_utype,
  output logic        is_lui,
  output logic        is_jalr,
  output logic        is_muldiv,
  output logic        illegal,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef struct packed {
    logic [1:0] result_src;
    logic       mem_write;
    logic       alu_src;
    logic [2:0] imm_src;
    logic       reg_write;
    logic [1:0] alu_op;
    logic       mreq;
    logic       is_branch;
    logic       jump;
    logic       is_utype;
    logic       is_lui;
    logic       is_jalr;
    logic       is_muldiv;
    logic       illegal;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } ctrl_t;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [15:0] ctl;
  logic        rs1_used;
  logic        rs2_used;
  logic        is_load;
  ctrl_t       dec;

  ctrl_t       bundle_d, bundle_q;
  logic        out_valid_d, out_valid_q;
  logic [4:0]  pend_rd_d, pend_rd_q;
  logic [1:0]  cnt_d, cnt_q;

  logic        adv;
  logic        hazard;
  logic        accept;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // ctl packs {result_src, mem_write, alu_src, imm_src, reg_write, alu_op,
  // mreq, is_branch, jump, is_utype, is_lui, is_jalr}
  always_comb begin
    ctl      = 16'b0;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    is_load  = 1'b0;
    dec      = '0;
    case (opcode)
      OP_LOAD:   begin ctl = 16'b01_0_1_000_1_00_1_0_0_0_0_0; rs1_used = 1'b1; is_load = 1'b1; end
      OP_IMM: begin
        ctl      = 16'b00_0_1_000_1_11_0_0_0_0_0_0;
        rs1_used = 1'b1;
        if (funct3 == 3'b001 || funct3 == 3'b101) ctl[11:9] = 3'b101;
      end
      OP_JALR:   begin ctl = 16'b00_0_1_000_1_10_0_1_1_0_0_1; rs1_used = 1'b1; end
      OP_STORE:  begin ctl = 16'b00_1_1_001_0_00_1_0_0_0_0_0; rs1_used = 1'b1; rs2_used = 1'b1; end
      OP_RTYPE:  begin ctl = 16'b00_0_0_000_1_10_0_0_0_0_0_0; rs1_used = 1'b1; rs2_used = 1'b1; end
      OP_BRANCH: begin ctl = 16'b00_0_0_010_0_01_0_1_0_0_0_0; rs1_used = 1'b1; rs2_used = 1'b1; end
      OP_JAL:    ctl = 16'b10_0_0_011_1_00_0_0_1_0_0_0;
      OP_AUIPC:  ctl = 16'b11_0_1_100_1_00_0_0_0_1_0_0;
      OP_LUI:    ctl = 16'b11_0_1_100_1_00_0_0_0_1_1_0;
      default:   dec.illegal = 1'b1;
    endcase
    {dec.result_src, dec.mem_write, dec.alu_src, dec.imm_src, dec.reg_write, dec.alu_op,
     dec.mreq, dec.is_branch, dec.jump, dec.is_utype, dec.is_lui, dec.is_jalr} = ctl;
    dec.is_muldiv = ENABLE_M && (opcode == OP_RTYPE) && (funct7 == 7'b0000001);
    dec.rd        = instr[11:7];
    dec.rs1       = instr[19:15];
    dec.rs2       = instr[24:20];
  end

  assign adv    = !out_valid_q || out_ready;
  assign hazard = (cnt_q != 2'd0) && in_valid &&
                  ((rs1_used && dec.rs1 != 5'd0 && dec.rs1 == pend_rd_q) ||
                   (rs2_used && dec.rs2 != 5'd0 && dec.rs2 == pend_rd_q));
  assign in_ready = adv && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    bundle_d    = bundle_q;
    out_valid_d = out_valid_q;
    pend_rd_d   = pend_rd_q;
    cnt_d       = cnt_q;
    if (flush) begin
      bundle_d    = '0;
      out_valid_d = 1'b0;
      cnt_d       = 2'd0;
    end else begin
      if (accept) begin
        bundle_d    = dec;
        out_valid_d = 1'b1;
      end else if (adv) begin
        bundle_d    = '0;
        out_valid_d = 1'b0;
      end
      // A fresh load restarts the countdown; otherwise it drains on every advancing cycle.
      if (accept && is_load && dec.rd != 5'd0) begin
        pend_rd_d = dec.rd;
        cnt_d     = 2'(LOAD_BUBBLES);
      end else if (adv && cnt_q != 2'd0) begin
        cnt_d = cnt_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bundle_q    <= '0;
      out_valid_q <= 1'b0;
      pend_rd_q   <= 5'd0;
      cnt_q       <= 2'd0;
    end else begin
      bundle_q    <= bundle_d;
      out_valid_q <= out_valid_d;
      pend_rd_q   <= pend_rd_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign result_src = bundle_q.result_src;
  assign mem_write  = bundle_q.mem_write;
  assign alu_src    = bundle_q.alu_src;
  assign imm_src    = bundle_q.imm_src;
  assign reg_write  = bundle_q.reg_write;
  assign alu_op     = bundle_q.alu_op;
  assign mreq       = bundle_q.mreq;
  assign is_branch  = bundle_q.is_branch;
  assign jump       = bundle_q.jump;
  assign is_utype   = bundle_q.is_utype;
  assign is_lui     = bundle_q.is_lui;
  assign is_jalr    = bundle_q.is_jalr;
  assign is_muldiv  = bundle_q.is_muldiv;
  assign illegal    = bundle_q.illegal;
  assign rd         = bundle_q.rd;
  assign rs1        = bundle_q.rs1;
  assign rs2        = bundle_q.rs2;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Directed bench for ctrl_decode_stage: decode table plus interlock, flush, stall and reset sequences.
module tb_ctrl_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, flush, out_ready;
  logic [31:0] instr;

  logic        in_ready, out_valid, mem_write, alu_src, reg_write, mreq, is_branch, jump;
  logic        is_utype, is_lui, is_jalr, is_muldiv, illegal;
  logic [1:0]  result_src, alu_op;
  logic [2:0]  imm_src;
  logic [4:0]  rd, rs1, rs2;

  logic        z_in_ready, z_out_valid, z_mem_write, z_alu_src, z_reg_write, z_mreq, z_is_branch;
  logic        z_jump, z_is_utype, z_is_lui, z_is_jalr, z_is_muldiv, z_illegal;
  logic [1:0]  z_result_src, z_alu_op;
  logic [2:0]  z_imm_src;
  logic [4:0]  z_rd, z_rs1, z_rs2;

  logic [15:0] m_ctl, z_ctl;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  ctrl_decode_stage #(.LOAD_BUBBLES(2), .ENABLE_M(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .flush(flush), .out_ready(out_ready), .out_valid(out_valid), .result_src(result_src),
    .mem_write(mem_write), .alu_src(alu_src), .imm_src(imm_src), .reg_write(reg_write),
    .alu_op(alu_op), .mreq(mreq), .is_branch(is_branch), .jump(jump), .is_utype(is_utype),
    .is_lui(is_lui), .is_jalr(is_jalr), .is_muldiv(is_muldiv), .illegal(illegal),
    .rd(rd), .rs1(rs1), .rs2(rs2)
  );

  ctrl_decode_stage #(.LOAD_BUBBLES(2), .ENABLE_M(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(z_in_ready), .instr(instr),
    .flush(flush), .out_ready(out_ready), .out_valid(z_out_valid), .result_src(z_result_src),
    .mem_write(z_mem_write), .alu_src(z_alu_src), .imm_src(z_imm_src), .reg_write(z_reg_write),
    .alu_op(z_alu_op), .mreq(z_mreq), .is_branch(z_is_branch), .jump(z_jump),
    .is_utype(z_is_utype), .is_lui(z_is_lui), .is_jalr(z_is_jalr), .is_muldiv(z_is_muldiv),
    .illegal(z_illegal), .rd(z_rd), .rs1(z_rs1), .rs2(z_rs2)
  );

  assign m_ctl = {result_src, mem_write, alu_src, imm_src, reg_write, alu_op,
                  mreq, is_branch, jump, is_utype, is_lui, is_jalr};
  assign z_ctl = {z_result_src, z_mem_write, z_alu_src, z_imm_src, z_reg_write, z_alu_op,
                  z_mreq, z_is_branch, z_jump, z_is_utype, z_is_lui, z_is_jalr};

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [15:0] ctl;
    logic        ill;
    logic        md;
    logic [4:0]  rd;
  } vec_t;

  vec_t vecs[12];

  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_JAL  = 32'h0000006F;
  localparam logic [31:0] I_LW5  = 32'h0002A283;
  localparam logic [31:0] I_DEP  = 32'h00128333;
  localparam logic [15:0] C_LOAD = 16'b01_0_1_000_1_00_1_0_0_0_0_0;
  localparam logic [15:0] C_IMM  = 16'b00_0_1_000_1_11_0_0_0_0_0_0;
  localparam logic [15:0] C_R    = 16'b00_0_0_000_1_10_0_0_0_0_0_0;
  localparam logic [15:0] C_JAL  = 16'b10_0_0_011_1_00_0_0_1_0_0_0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{"addi",   I_ADDI,       C_IMM,                          1'b0, 1'b0, 5'd1};
    vecs[1]  = '{"slli",   32'h00309093, 16'b00_0_1_101_1_11_0_0_0_0_0_0, 1'b0, 1'b0, 5'd1};
    vecs[2]  = '{"add",    I_ADD,        C_R,                            1'b0, 1'b0, 5'd3};
    vecs[3]  = '{"jal",    I_JAL,        C_JAL,                          1'b0, 1'b0, 5'd0};
    vecs[4]  = '{"lw",     I_LW5,        C_LOAD,                         1'b0, 1'b0, 5'd5};
    vecs[5]  = '{"sw",     32'h0020A023, 16'b00_1_1_001_0_00_1_0_0_0_0_0, 1'b0, 1'b0, 5'd0};
    vecs[6]  = '{"beq",    32'h00208063, 16'b00_0_0_010_0_01_0_1_0_0_0_0, 1'b0, 1'b0, 5'd0};
    vecs[7]  = '{"jalr",   32'h000100E7, 16'b00_0_1_000_1_10_0_1_1_0_0_1, 1'b0, 1'b0, 5'd1};
    vecs[8]  = '{"auipc",  32'h00001097, 16'b11_0_1_100_1_00_0_0_0_1_0_0, 1'b0, 1'b0, 5'd1};
    vecs[9]  = '{"lui",    32'h000010B7, 16'b11_0_1_100_1_00_0_0_0_1_1_0, 1'b0, 1'b0, 5'd1};
    vecs[10] = '{"illeg",  32'h0000007F, 16'b0,                          1'b1, 1'b0, 5'd0};
    vecs[11] = '{"mul",    32'h02208033, C_R,                            1'b0, 1'b1, 5'd0};

    rst_n = 1'b0; in_valid = 1'b0; instr = '0; flush = 1'b0; out_ready = 1'b1;
    #3;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_ctl", 32'(m_ctl), 0);
    #10 rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", 32'(in_ready), 1);
    chk("post_rst_out_valid", 32'(out_valid), 0);

    // Decode table, each instruction isolated by idle cycles
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; instr = vecs[i].instr;
      #1 chk({vecs[i].name, "_in_ready"}, 32'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      chk({vecs[i].name, "_out_valid"}, 32'(out_valid), 1);
      chk({vecs[i].name, "_ctl"}, 32'(m_ctl), 32'(vecs[i].ctl));
      chk({vecs[i].name, "_illegal"}, 32'(illegal), 32'(vecs[i].ill));
      chk({vecs[i].name, "_muldiv_m1"}, 32'(is_muldiv), 32'(vecs[i].md));
      chk({vecs[i].name, "_muldiv_m0"}, 32'(z_is_muldiv), 0);
      chk({vecs[i].name, "_ctl_m0"}, 32'(z_ctl), 32'(vecs[i].ctl));
      chk({vecs[i].name, "_rd"}, 32'(rd), 32'(vecs[i].rd));
      tick();
      chk({vecs[i].name, "_bubble_valid"}, 32'(out_valid), 0);
      chk({vecs[i].name, "_bubble_ctl"}, 32'({m_ctl, illegal, is_muldiv, rd}), 0);
      tick();
      tick();
    end

    // Asynchronous reset while a bundle is held
    in_valid = 1'b1; instr = I_ADDI;
    tick();
    in_valid = 1'b0;
    chk("pre_rst_valid", 32'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 0);
    chk("async_rst_bundle", 32'({m_ctl, illegal, is_muldiv, rd, rs1, rs2}), 0);
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 32'(in_ready), 1);
    chk("rel_out_valid", 32'(out_valid), 0);
    tick();

    // Back-to-back stream
    in_valid = 1'b1; instr = I_ADDI;
    #1 chk("s_addi_rdy", 32'(in_ready), 1);
    tick();
    chk("s_addi_valid", 32'(out_valid), 1);
    chk("s_addi_aluop", 32'(alu_op), 32'b11);
    chk("s_addi_imm", 32'(imm_src), 32'b000);
    instr = I_ADD;
    #1 chk("s_add_rdy", 32'(in_ready), 1);
    tick();
    chk("s_add_valid", 32'(out_valid), 1);
    chk("s_add_ctl", 32'(m_ctl), 32'(C_R));
    instr = I_JAL;
    #1 chk("s_jal_rdy", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    chk("s_jal_valid", 32'(out_valid), 1);
    chk("s_jal_rsrc", 32'(result_src), 32'b10);
    chk("s_jal_jump", 32'(jump), 1);
    tick();
    chk("s_end_valid", 32'(out_valid), 0);

    // Load-use: two bubbles
    in_valid = 1'b1; instr = I_LW5;
    tick();
    chk("lu_load_valid", 32'(out_valid), 1);
    instr = I_DEP;
    #1 chk("lu_stall0_rdy", 32'(in_ready), 0);
    tick();
    chk("lu_b1_valid", 32'(out_valid), 0);
    chk("lu_stall1_rdy", 32'(in_ready), 0);
    tick();
    chk("lu_b2_valid", 32'(out_valid), 0);
    chk("lu_go_rdy", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    chk("lu_dep_valid", 32'(out_valid), 1);
    chk("lu_dep_rd", 32'(rd), 6);
    tick(); tick();

    // Load followed by an unrelated instruction
    in_valid = 1'b1; instr = I_LW5;
    tick();
    instr = I_ADD;
    #1 chk("nr_rdy", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    chk("nr_valid", 32'(out_valid), 1);
    chk("nr_rd", 32'(rd), 3);
    tick(); tick(); tick();

    // Flush on the stall cycle clears the interlock
    in_valid = 1'b1; instr = I_LW5;
    tick();
    instr = I_DEP; flush = 1'b1;
    #1 chk("fl_rdy", 32'(in_ready), 0);
    tick();
    flush = 1'b0;
    chk("fl_valid", 32'(out_valid), 0);
    chk("fl_ctl", 32'(m_ctl), 0);
    #1 chk("fl_next_rdy", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    chk("fl_next_valid", 32'(out_valid), 1);
    chk("fl_next_rd", 32'(rd), 6);
    tick();

    // Downstream stall holds the bundle and freezes the countdown
    in_valid = 1'b1; instr = I_LW5;
    tick();
    out_ready = 1'b0; instr = I_DEP;
    for (int k = 0; k < 3; k++) begin
      #1 chk("st_rdy", 32'(in_ready), 0);
      tick();
      chk("st_valid", 32'(out_valid), 1);
      chk("st_ctl", 32'(m_ctl), 32'(C_LOAD));
      chk("st_rd", 32'(rd), 5);
    end
    out_ready = 1'b1;
    #1 chk("st_rel_rdy0", 32'(in_ready), 0);
    tick();
    chk("st_rel_valid0", 32'(out_valid), 0);
    chk("st_rel_rdy1", 32'(in_ready), 0);
    tick();
    chk("st_rel_valid1", 32'(out_valid), 0);
    chk("st_rel_rdy2", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    chk("st_dep_valid", 32'(out_valid), 1);
    chk("st_dep_rd", 32'(rd), 6);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
